// File: rtl/updown_sweep_ctrl.sv
// Triangle sweep sequencer: drives an owned up/down count register lo -> hi -> lo
// for a programmed number of sweeps, with start/pause/abort control and done/err pulses.
module updown_sweep_ctrl #(
    parameter int N  = 5,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          pause,
    input  logic [N-1:0]  lo,
    input  logic [N-1:0]  hi,
    input  logic [CW-1:0] num_sweeps,
    output logic [N-1:0]  count,
    output logic          up_down,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [CW-1:0] sweeps_done
);

    typedef enum logic [1:0] {
        IDLE,
        UP,
        DOWN,
        DONE
    } state_t;

    localparam logic [N-1:0]  COUNT_ONE = 1;
    localparam logic [CW-1:0] SWEEP_ONE = 1;

    state_t        state;
    logic [N-1:0]  lo_l;
    logic [N-1:0]  hi_l;
    logic [CW-1:0] num_l;

    logic [N-1:0]  count_inc;
    logic [N-1:0]  count_dec;
    logic [CW-1:0] sweeps_inc;

    always_comb begin
        count_inc  = count + COUNT_ONE;
        count_dec  = count - COUNT_ONE;
        sweeps_inc = sweeps_done + SWEEP_ONE;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            count       <= '0;
            up_down     <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            sweeps_done <= '0;
            lo_l        <= '0;
            hi_l        <= '0;
            num_l       <= '0;
        end else begin
            err  <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    // start together with abort is treated as no request at all
                    if (start && !abort) begin
                        if ((lo < hi) && (num_sweeps != '0)) begin
                            lo_l        <= lo;
                            hi_l        <= hi;
                            num_l       <= num_sweeps;
                            count       <= lo;
                            up_down     <= 1'b1;
                            sweeps_done <= '0;
                            busy        <= 1'b1;
                            state       <= UP;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                UP: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (!pause) begin
                        count <= count_inc;
                        if (count_inc == hi_l) begin
                            up_down <= 1'b0;
                            state   <= DOWN;
                        end
                    end
                end
                DOWN: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (!pause) begin
                        count <= count_dec;
                        // reaching lo completes a sweep; the final one ends the run
                        if (count_dec == lo_l) begin
                            sweeps_done <= sweeps_inc;
                            if (sweeps_inc == num_l) begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= DONE;
                            end else begin
                                up_down <= 1'b1;
                                state   <= UP;
                            end
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
